// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps FETCH/DECODE/EXEC/MEM/WB, times the datapath
// strobes and owns the shared request/ready memory port with a wait-cycle watchdog.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             reg_we,
   output logic [2:0]       state,
   output logic             fault,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_FAULT  = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_ALU   = 2'b10;

   state_t      cur_state;
   state_t      next_state;
   logic        req_active;
   logic        req_active_next;
   logic [31:0] wait_cnt;
   logic [31:0] wait_cnt_next;
   logic        retire;
   logic        is_legal;

   assign state    = cur_state;
   assign is_legal = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

   // Next state and all strobes; the watchdog below may override next_state.
   always_comb begin
      next_state      = cur_state;
      req_active_next = req_active;
      wait_cnt_next   = wait_cnt;
      retire          = 1'b0;
      mem_req         = 1'b0;
      mem_we          = 1'b0;
      addr_sel        = 1'b0;
      ir_we           = 1'b0;
      pc_we           = 1'b0;
      pc_sel          = PC_PLUS4;
      reg_we          = 1'b0;

      case (cur_state)
         ST_FETCH: begin
            if (req_active || run) begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we           = 1'b1;
                  req_active_next = 1'b0;
                  next_state      = ST_DECODE;
               end else begin
                  req_active_next = 1'b1;
               end
            end
         end
         ST_DECODE: next_state = is_legal ? ST_EXEC : ST_FAULT;
         ST_EXEC: begin
            case (opcode)
               OP_R, OP_I, OP_LUI, OP_AUIPC: next_state = ST_WB;
               OP_LOAD, OP_STORE:            next_state = ST_MEM;
               OP_BRANCH: begin
                  pc_we      = 1'b1;
                  pc_sel     = branch_taken ? PC_IMM : PC_PLUS4;
                  retire     = 1'b1;
                  next_state = ST_FETCH;
               end
               OP_JAL: begin
                  reg_we     = 1'b1;
                  pc_we      = 1'b1;
                  pc_sel     = PC_IMM;
                  retire     = 1'b1;
                  next_state = ST_FETCH;
               end
               OP_JALR: begin
                  reg_we     = 1'b1;
                  pc_we      = 1'b1;
                  pc_sel     = PC_ALU;
                  retire     = 1'b1;
                  next_state = ST_FETCH;
               end
               default: next_state = ST_FAULT;
            endcase
         end
         ST_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == OP_STORE);
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  pc_we      = 1'b1;
                  retire     = 1'b1;
                  next_state = ST_FETCH;
               end else begin
                  next_state = ST_WB;
               end
            end
         end
         ST_WB: begin
            reg_we     = 1'b1;
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = ST_FETCH;
         end
         ST_FAULT: next_state = ST_FAULT;
         default:  next_state = ST_FAULT;
      endcase

      // A ready in the expiry cycle still completes; only a missing ready faults.
      if (mem_req) begin
         if (mem_ready) begin
            wait_cnt_next = '0;
         end else if ((TIMEOUT != 0) && (wait_cnt == TIMEOUT)) begin
            next_state      = ST_FAULT;
            req_active_next = 1'b0;
         end else begin
            wait_cnt_next = wait_cnt + 32'd1;
         end
      end
      if (next_state != cur_state) begin
         wait_cnt_next = '0;
      end
   end

   // State, handshake bookkeeping, sticky fault and retire counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_state  <= ST_FETCH;
         req_active <= 1'b0;
         wait_cnt   <= '0;
         fault      <= 1'b0;
         instret    <= '0;
      end else begin
         cur_state  <= next_state;
         req_active <= req_active_next;
         wait_cnt   <= wait_cnt_next;
         if (next_state == ST_FAULT) begin
            fault <= 1'b1;
         end
         if (retire) begin
            instret <= instret + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the driver queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_ctrl;

   localparam logic [6:0] ADD  = 7'b0110011;
   localparam logic [6:0] ADDI = 7'b0010011;
   localparam logic [6:0] LD   = 7'b0000011;
   localparam logic [6:0] ST   = 7'b0100011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] LUI  = 7'b0110111;
   localparam logic [6:0] AUI  = 7'b0010111;
   localparam logic [6:0] BAD  = 7'b0000000;

   // strobe order: mem_req mem_we addr_sel ir_we pc_we pc_sel[1:0] reg_we fault
   localparam logic [8:0] S_NONE  = 9'b0_0_0_0_0_00_0_0;
   localparam logic [8:0] S_FREQ  = 9'b1_0_0_0_0_00_0_0;
   localparam logic [8:0] S_FDONE = 9'b1_0_0_1_0_00_0_0;
   localparam logic [8:0] S_BRT   = 9'b0_0_0_0_1_01_0_0;
   localparam logic [8:0] S_BRN   = 9'b0_0_0_0_1_00_0_0;
   localparam logic [8:0] S_JAL   = 9'b0_0_0_0_1_01_1_0;
   localparam logic [8:0] S_JALR  = 9'b0_0_0_0_1_10_1_0;
   localparam logic [8:0] S_MLD   = 9'b1_0_1_0_0_00_0_0;
   localparam logic [8:0] S_MST   = 9'b1_1_1_0_0_00_0_0;
   localparam logic [8:0] S_STDN  = 9'b1_1_1_0_1_00_0_0;
   localparam logic [8:0] S_WB    = 9'b0_0_0_0_1_00_1_0;
   localparam logic [8:0] S_FLT   = 9'b0_0_0_0_0_00_0_1;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [8:0] strb;
      logic [3:0] ir;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       run;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       addr_sel;
   logic       ir_we;
   logic       pc_we;
   logic [1:0] pc_sel;
   logic       reg_we;
   logic [2:0] state;
   logic       fault;
   logic [3:0] instret;

   exp_t       sb[$];
   string      cur_test;
   logic [3:0] exp_instret;
   int         checks;
   int         errors;

   multicycle_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
      .branch_taken(branch_taken), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
      .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .state(state),
      .fault(fault), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input exp_t e);
      logic [8:0] act;
      act = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, reg_we, fault};
      checks += 3;
      if (state !== e.st) begin
         errors++;
         $display("[TB] FAIL %s state: got %0d want %0d", e.tag, state, e.st);
      end
      if (act !== e.strb) begin
         errors++;
         $display("[TB] FAIL %s strobes: got %b want %b", e.tag, act, e.strb);
      end
      if (instret !== e.ir) begin
         errors++;
         $display("[TB] FAIL %s instret: got %0d want %0d", e.tag, instret, e.ir);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         checkOutput(sb.pop_front());
      end
   end

   // One cycle of stimulus; the expected outputs for that same cycle are queued.
   task automatic applyStimulus(input logic r, input logic [6:0] op, input logic bt,
                                input logic rdy, input logic [2:0] st,
                                input logic [8:0] strb, input logic ret);
      exp_t e;
      run          = r;
      opcode       = op;
      branch_taken = bt;
      mem_ready    = rdy;
      e.tag  = cur_test;
      e.st   = st;
      e.strb = strb;
      e.ir   = exp_instret;
      sb.push_back(e);
      if (ret) exp_instret = exp_instret + 4'd1;
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      cur_test    = "reset";
      rst_n       = 1'b0;
      exp_instret = 4'd0;
      applyStimulus(1'b1, ADD, 1'b0, 1'b0, 3'd0, S_FREQ, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic fetchDecode(input logic [6:0] op);
      applyStimulus(1'b1, op, 1'b0, 1'b1, 3'd0, S_FDONE, 1'b0);
      applyStimulus(1'b1, op, 1'b0, 1'b1, 3'd1, S_NONE, 1'b0);
   endtask

   initial begin
      checks = 0; errors = 0; exp_instret = 4'd0; cur_test = "init";
      rst_n = 1'b0; run = 1'b0; opcode = ADD; branch_taken = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;
      doReset();

      cur_test = "add";
      fetchDecode(ADD);
      applyStimulus(1'b1, ADD, 1'b0, 1'b1, 3'd2, S_NONE, 1'b0);
      applyStimulus(1'b1, ADD, 1'b0, 1'b1, 3'd4, S_WB, 1'b1);

      cur_test = "load_wait3";
      applyStimulus(1'b1, LD, 1'b0, 1'b1, 3'd0, S_FDONE, 1'b0);
      applyStimulus(1'b1, LD, 1'b0, 1'b0, 3'd1, S_NONE, 1'b0);
      applyStimulus(1'b1, LD, 1'b0, 1'b0, 3'd2, S_NONE, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, LD, 1'b0, 1'b0, 3'd3, S_MLD, 1'b0);
      applyStimulus(1'b1, LD, 1'b0, 1'b1, 3'd3, S_MLD, 1'b0);
      applyStimulus(1'b1, LD, 1'b0, 1'b0, 3'd4, S_WB, 1'b1);

      cur_test = "branch_taken";
      fetchDecode(BR);
      applyStimulus(1'b1, BR, 1'b1, 1'b1, 3'd2, S_BRT, 1'b1);
      cur_test = "branch_not";
      fetchDecode(BR);
      applyStimulus(1'b1, BR, 1'b0, 1'b1, 3'd2, S_BRN, 1'b1);

      cur_test = "jal";
      fetchDecode(JAL);
      applyStimulus(1'b1, JAL, 1'b0, 1'b1, 3'd2, S_JAL, 1'b1);
      cur_test = "jalr";
      fetchDecode(JALR);
      applyStimulus(1'b1, JALR, 1'b0, 1'b1, 3'd2, S_JALR, 1'b1);

      cur_test = "store_wait1";
      fetchDecode(ST);
      applyStimulus(1'b1, ST, 1'b0, 1'b1, 3'd2, S_NONE, 1'b0);
      applyStimulus(1'b1, ST, 1'b0, 1'b0, 3'd3, S_MST, 1'b0);
      applyStimulus(1'b1, ST, 1'b0, 1'b1, 3'd3, S_STDN, 1'b1);

      // idle fetch ignores mem_ready; dropping run mid-request keeps the request
      cur_test = "run_drop_lui";
      applyStimulus(1'b0, LUI, 1'b0, 1'b1, 3'd0, S_NONE, 1'b0);
      applyStimulus(1'b1, LUI, 1'b0, 1'b0, 3'd0, S_FREQ, 1'b0);
      applyStimulus(1'b0, LUI, 1'b0, 1'b0, 3'd0, S_FREQ, 1'b0);
      applyStimulus(1'b0, LUI, 1'b0, 1'b1, 3'd0, S_FDONE, 1'b0);
      applyStimulus(1'b0, LUI, 1'b0, 1'b1, 3'd1, S_NONE, 1'b0);
      applyStimulus(1'b0, LUI, 1'b0, 1'b1, 3'd2, S_NONE, 1'b0);
      applyStimulus(1'b0, LUI, 1'b0, 1'b1, 3'd4, S_WB, 1'b1);

      cur_test = "ready_at_limit";
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, AUI, 1'b0, 1'b0, 3'd0, S_FREQ, 1'b0);
      applyStimulus(1'b1, AUI, 1'b0, 1'b1, 3'd0, S_FDONE, 1'b0);
      applyStimulus(1'b1, AUI, 1'b0, 1'b1, 3'd1, S_NONE, 1'b0);
      applyStimulus(1'b1, AUI, 1'b0, 1'b1, 3'd2, S_NONE, 1'b0);
      applyStimulus(1'b1, AUI, 1'b0, 1'b1, 3'd4, S_WB, 1'b1);

      cur_test = "addi";
      fetchDecode(ADDI);
      applyStimulus(1'b1, ADDI, 1'b0, 1'b1, 3'd2, S_NONE, 1'b0);
      applyStimulus(1'b1, ADDI, 1'b0, 1'b1, 3'd4, S_WB, 1'b1);

      // ten retired so far; six more wrap the 4-bit counter to zero
      cur_test = "instret_wrap";
      for (int i = 0; i < 6; i++) begin
         fetchDecode(JAL);
         applyStimulus(1'b1, JAL, 1'b0, 1'b1, 3'd2, S_JAL, 1'b1);
      end

      cur_test = "fetch_timeout";
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, ADD, 1'b0, 1'b0, 3'd0, S_FREQ, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, ADD, 1'b0, i[0], 3'd7, S_FLT, 1'b0);
      doReset();

      cur_test = "illegal_op";
      fetchDecode(BAD);
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, BAD, 1'b1, 1'b1, 3'd7, S_FLT, 1'b0);
      doReset();

      cur_test = "add_after_reset";
      fetchDecode(ADD);
      applyStimulus(1'b1, ADD, 1'b0, 1'b1, 3'd2, S_NONE, 1'b0);
      applyStimulus(1'b1, ADD, 1'b0, 1'b1, 3'd4, S_WB, 1'b1);
      applyStimulus(1'b0, ADD, 1'b0, 1'b0, 3'd0, S_NONE, 1'b0);

      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d queued want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the RV32I core datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the datapath write strobes and mux selects, and owns a single shared request/ready memory port used for both instruction fetch and data access. It sits beside the combinational instruction decoder, which supplies per-opcode datapath settings; this block supplies only the per-cycle timing of those settings.

## Interface
- `TIMEOUT`, default 255: maximum number of cycles a memory request waits for `mem_ready` before FAULT. 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  permission to start a new fetch.
- `opcode`  in  7  instruction opcode from the IR; valid from DECODE onward.
- `branch_taken`  in  1  branch compare result; valid in EXEC.
- `mem_ready`  in  1  memory completion for the current request.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  store qualifier for `mem_req`.
- `addr_sel`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  instruction register load.
- `pc_we`  out  1  PC load.
- `pc_sel`  out  2  next-PC select: 00 = PC+4, 01 = PC+imm, 10 = ALU result (jalr).
- `reg_we`  out  1  register file write.
- `state`  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7.
- `fault`  out  1  sticky fault flag.
- `instret`  out  CNT_W  count of retired instructions.

## Operation
- Registered: state, `req_active` flag, wait counter, `fault`, `instret`. All strobes and selects are combinational from state, `opcode`, `branch_taken` and `mem_ready`. Any strobe not listed in a state is 0.
- FETCH:
  - If `req_active` = 0 and `run` = 0: idle, no request.
  - Otherwise `mem_req` = 1, `addr_sel` = 0, `mem_we` = 0.
  - On `mem_ready` = 1: `ir_we` = 1, clear `req_active`, go to DECODE.
  - Otherwise set `req_active`.
  - Once the request starts, `run` is ignored until the fetch completes; a request is never retracted.
- DECODE: one cycle.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Legal opcode: go to EXEC. Any other opcode: go to FAULT.
- EXEC: one cycle.
  - R, I, LUI, AUIPC: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: `pc_we` = 1, `pc_sel` = 01 if `branch_taken` else 00; retire; go to FETCH.
  - JAL: `reg_we` = 1, `pc_we` = 1, `pc_sel` = 01; retire; go to FETCH.
  - JALR: `reg_we` = 1, `pc_we` = 1, `pc_sel` = 10; retire; go to FETCH.
- MEM:
  - `mem_req` = 1, `addr_sel` = 1, `mem_we` = 1 for STORE.
  - On `mem_ready`, STORE: `pc_we` = 1, `pc_sel` = 00; retire; go to FETCH.
  - On `mem_ready`, LOAD: go to WB.
- WB: `reg_we` = 1, `pc_we` = 1, `pc_sel` = 00; retire; go to FETCH.
- FAULT: all strobes 0, `fault` = 1. Held until `rst_n` is asserted.
- Retire: `instret` += 1 modulo 2^CNT_W; all-ones wraps to 0.
- Timeout:
  - The wait counter clears when a request completes and on every state change.
  - It increments each cycle `mem_req` = 1 and `mem_ready` = 0.
  - If it reaches `TIMEOUT` with `mem_ready` still 0, go to FAULT next cycle.
  - `mem_ready` = 1 in that same cycle wins: the request completes normally.
- `mem_ready` while `mem_req` = 0 is ignored.

## Timing
- Reset (asynchronous, immediate):
  - state = FETCH, `req_active` = 0, wait counter = 0, `fault` = 0, `instret` = 0.
  - Outputs during reset: `mem_req` = `run`, `addr_sel` = 0; all other strobes 0, `pc_sel` = 00.
- Reset in mid-operation (including mid-request or FAULT) abandons the instruction; the memory must tolerate the dropped request.
- Handshake:
  - `mem_req`, `mem_we` and `addr_sel` are held stable from request start to the completion cycle.
  - Completion is the cycle `mem_ready` = 1 is sampled.
  - Zero-wait memory (ready in the first request cycle) is legal.
- Cycles per instruction with zero-wait memory: BRANCH/JAL/JALR 3; R/I/LUI/AUIPC 4; STORE 4; LOAD 5. Each memory wait cycle adds 1.
- `instret` updates on the clock edge that ends the retiring cycle.

## Test plan
- Reset with `run` = 1 and zero-wait memory; run ADD (0110011) → `state` 0,1,2,4,0; `reg_we` and `pc_we` high only in cycle 4; `instret` = 1.
- LOAD with `mem_ready` delayed 3 cycles in MEM → `mem_req` high with `addr_sel` = 1 for 4 cycles; WB follows; total 8 cycles; `instret` +1.
- BRANCH with `branch_taken` = 1, then 0 → `pc_sel` = 01, then 00, in EXEC; `reg_we` never high; 3 cycles each.
- Opcode 0000000 in DECODE → `state` = 7, `fault` = 1, all strobes 0 for 20 cycles; `rst_n` low → `state` 0, `fault` 0.
- `TIMEOUT` = 4, fetch never ready → FAULT after 4 wait cycles; repeat with ready in the 5th cycle → DECODE, no fault.
- `run` dropped after the fetch request starts → request held until ready. `CNT_W` = 4 after 16 retires → `instret` wraps to 0.
